matvec_engine: RTL and testbench

//  Downstream consumer of the row fetcher's byte stream. Buffers 8 A-row byte streams and 1 B-vector

---
 rtl/matvec_pkg.sv | 23 ++
 rtl/byte_fifo.sv | 56 +++++
 rtl/matvec_engine.sv | 165 ++++++++++++++++
 tb/tb_matvec_engine.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared constants, FSM state type and lane scheduling helper for the matvec engine.
package matvec_pkg;

  localparam int unsigned DIM    = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned B_SEL  = DIM;
  localparam int unsigned STEPS  = 2 * DIM - 1;
  localparam int unsigned STEP_W = $clog2(STEPS);
  localparam int unsigned CNT_W  = $clog2(DIM + 1);

  typedef enum logic [1:0] {
    FILL,
    COMPUTE,
    DONE
  } state_t;

  // Lane i consumes its A row during steps i .. i+DIM-1 of the systolic sweep.
  function automatic logic lane_active(input int unsigned t, input int unsigned i);
    return (t >= i) && (t < i + DIM);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with first-word-fall-through output and occupancy count.
module byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/matvec_engine.sv
// Buffers DIM A rows plus the B vector, then sweeps them systolically through DIM MAC lanes (C = A x B).
// Build option: define MATVEC_SIGNED_EN for two's-complement elements and signed accumulation.
module matvec_engine
  import matvec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     fifo_data,
  input  logic [3:0]            fifo_sel,
  input  logic                  fifo_wren,
  input  logic                  clear,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DIM*ACC_W-1:0]  result
);

  state_t            state;
  state_t            state_next;
  logic [STEP_W-1:0] step;
  int unsigned       t_now;
  logic              flush;

  logic [DATA_W-1:0] q   [DIM+1];
  logic [CNT_W-1:0]  cnt [DIM+1];
  logic [DIM:0]      push;
  logic [DIM:0]      pop;
  logic [DIM:0]      full;
  logic [DIM:0]      empty;
  logic [DIM-1:0]    lane_en;
  logic              all_full;
  logic              sel_legal;
  logic              target_full;
  logic              wr_ok;
  logic              wr_drop;

  logic [DATA_W-1:0] b_sr [DIM-1];

  assign flush     = rst || clear;
  assign t_now     = 32'(step);
  assign sel_legal = (fifo_sel <= 4'(B_SEL));

  // Write routing; clear wins over a simultaneous write, which is then neither stored nor flagged.
  always_comb begin
    push        = '0;
    target_full = 1'b0;
    for (int unsigned k = 0; k <= DIM; k++) begin
      if (fifo_sel == 4'(k)) target_full = full[k];
    end
    wr_ok   = fifo_wren && !clear && (state == FILL) && sel_legal && !target_full;
    wr_drop = fifo_wren && !clear && !wr_ok;
    for (int unsigned k = 0; k <= DIM; k++) begin
      push[k] = wr_ok && (fifo_sel == 4'(k));
    end
  end

  always_comb begin
    all_full = 1'b1;
    for (int unsigned k = 0; k <= DIM; k++) begin
      if (cnt[k] != CNT_W'(DIM)) all_full = 1'b0;
    end
  end

  always_comb begin
    lane_en = '0;
    pop     = '0;
    if (state == COMPUTE) begin
      for (int unsigned i = 0; i < DIM; i++) begin
        lane_en[i] = lane_active(t_now, i);
        pop[i]     = lane_en[i] && !empty[i];
      end
      pop[B_SEL] = (t_now < DIM) && !empty[B_SEL];
    end
  end

  for (genvar k = 0; k <= DIM; k++) begin : g_fifo
    byte_fifo #(
      .DEPTH(DIM),
      .WIDTH(DATA_W)
    ) u_fifo (
      .clk  (clk),
      .rst  (flush),
      .push (push[k]),
      .pop  (pop[k]),
      .din  (fifo_data),
      .dout (q[k]),
      .count(cnt[k]),
      .full (full[k]),
      .empty(empty[k])
    );
  end

  // B skew chain: b_sr[k] carries the B element popped k+1 steps ago.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int unsigned k = 0; k < DIM - 1; k++) b_sr[k] <= '0;
    end else if (state == COMPUTE) begin
      b_sr[0] <= pop[B_SEL] ? q[B_SEL] : '0;
      for (int unsigned k = 1; k < DIM - 1; k++) b_sr[k] <= b_sr[k-1];
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [DATA_W-1:0]   b_in;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    acc;

    if (i == 0) begin : g_head
      assign b_in = q[B_SEL];
    end else begin : g_tap
      assign b_in = b_sr[i-1];
    end

`ifdef MATVEC_SIGNED_EN
    assign prod = $signed({{DATA_W{q[i][DATA_W-1]}}, q[i]})
                * $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`else
    assign prod = {{DATA_W{1'b0}}, q[i]} * {{DATA_W{1'b0}}, b_in};
    assign prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, prod};
`endif

    always_ff @(posedge clk) begin
      if (flush) begin
        acc <= '0;
      end else if (lane_en[i]) begin
        acc <= acc + prod_ext;
      end
    end

    assign result[i*ACC_W +: ACC_W] = acc;
  end

  always_ff @(posedge clk) begin
    if (flush) state <= FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (all_full) state_next = COMPUTE;
      COMPUTE: if (step == STEP_W'(STEPS - 1)) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    busy = (state == COMPUTE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (flush || state != COMPUTE) step <= '0;
    else                           step <= step + STEP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (wr_drop) err <= 1'b1;
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Scoreboard bench for matvec_engine: expected result vectors are queued at load time and popped at done.
module tb_matvec_engine;
  import matvec_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DATA_W-1:0]    fifo_data;
  logic [3:0]           fifo_sel;
  logic                 fifo_wren;
  logic                 clear;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [DIM*ACC_W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DIM*ACC_W-1:0] exp_q [$];
  logic [DATA_W-1:0]    mat_a [DIM][DIM];
  logic [DATA_W-1:0]    vec_b [DIM];

  matvec_engine dut (
    .clk      (clk),
    .rst      (rst),
    .fifo_data(fifo_data),
    .fifo_sel (fifo_sel),
    .fifo_wren(fifo_wren),
    .clear    (clear),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [DIM*ACC_W-1:0] model_result();
    logic [DIM*ACC_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++) begin
      int sum;
      sum = 0;
      for (int j = 0; j < DIM; j++) begin
        int av;
        int bv;
`ifdef MATVEC_SIGNED_EN
        av = int'($signed(mat_a[i][j]));
        bv = int'($signed(vec_b[j]));
`else
        av = int'(mat_a[i][j]);
        bv = int'(vec_b[j]);
`endif
        sum += av * bv;
      end
      r[i*ACC_W +: ACC_W] = sum[ACC_W-1:0];
    end
    return r;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) mat_a[i][j] = DATA_W'($urandom_range(255, 0));
      vec_b[i] = DATA_W'($urandom_range(255, 0));
    end
  endtask

  task automatic do_write(input int sel, input logic [DATA_W-1:0] d);
    fifo_sel  = 4'(sel);
    fifo_data = d;
    fifo_wren = 1'b1;
    @(posedge clk); #1;
    fifo_wren = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      for (int j = 0; j < DIM; j++) do_write(i, mat_a[i][j]);
    end
  endtask

  task automatic load_b();
    for (int j = 0; j < DIM; j++) do_write(B_SEL, vec_b[j]);
  endtask

  // Called right after the edge that sampled the final write.
  task automatic wait_done(input string name);
    int edges;
    int busy_cycles;
    logic [DIM*ACC_W-1:0] want;
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 64) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cycles++;
    end
    n_cmp++;
    if (edges !== 2 * DIM) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d edges to done, want %0d", name, edges, 2 * DIM);
    end
    n_cmp++;
    if (busy_cycles !== 2 * DIM - 1) begin
      n_bad++;
      $display("FAIL %s_busy: got %0d busy cycles, want %0d", name, busy_cycles, 2 * DIM - 1);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s_result: got %h, want <scoreboard empty>", name, result);
    end else begin
      want = exp_q.pop_front();
      if (result !== want) begin
        n_bad++;
        $display("FAIL %s_result: got %h, want %h", name, result, want);
      end
    end
  endtask

  task automatic test_reset();
    clk       = 1'b0;
    rst       = 1'b1;
    clear     = 1'b0;
    fifo_wren = 1'b0;
    fifo_sel  = '0;
    fifo_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b, want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b, want 0", err); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h, want 0", result); end
  endtask

  task automatic test_identity();
    logic [DIM*ACC_W-1:0] held;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) mat_a[i][j] = (i == j) ? DATA_W'(1) : '0;
      vec_b[i] = DATA_W'(i + 1);
    end
    held = model_result();
    exp_q.push_back(held);
    load_rows(0, DIM - 1);
    load_b();
    wait_done("identity");
    n_cmp++;
    if (result[3*ACC_W +: ACC_W] !== ACC_W'(4)) begin
      n_bad++;
      $display("FAIL identity_lane3: got %0d, want 4", result[3*ACC_W +: ACC_W]);
    end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL identity_err: got %b, want 0", err); end
    do_write(0, 8'h55);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL done_write_err: got %b, want 1", err); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL done_write_done: got %b, want 1", done); end
    n_cmp++;
    if (result !== held) begin
      n_bad++;
      $display("FAIL done_write_result: got %h, want %h", result, held);
    end
    do_clear();
  endtask

  task automatic test_all_ff();
    logic [ACC_W-1:0] lane_want;
`ifdef MATVEC_SIGNED_EN
    lane_want = ACC_W'(8);
`else
    lane_want = 24'h07F008;
`endif
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) mat_a[i][j] = 8'hFF;
      vec_b[i] = 8'hFF;
    end
    exp_q.push_back(model_result());
    load_rows(0, DIM - 1);
    load_b();
    wait_done("all_ff");
    n_cmp++;
    if (result[0 +: ACC_W] !== lane_want) begin
      n_bad++;
      $display("FAIL all_ff_lane0: got %h, want %h", result[0 +: ACC_W], lane_want);
    end
    do_clear();
  endtask

  task automatic test_interleaved();
    int idx [DIM+1];
    int left;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) mat_a[i][j] = (j == 0) ? DATA_W'(i) : '0;
      vec_b[i] = (i == 0) ? DATA_W'(3) : DATA_W'($urandom_range(255, 0));
    end
    for (int k = 0; k <= DIM; k++) idx[k] = 0;
    exp_q.push_back(model_result());
    left = (DIM + 1) * DIM;
    while (left > 0) begin
      int s;
      s = int'($urandom_range(DIM, 0));
      if (idx[s] < DIM) begin
        do_write(s, (s == B_SEL) ? vec_b[idx[s]] : mat_a[s][idx[s]]);
        idx[s]++;
        left--;
      end
    end
    wait_done("interleaved");
    n_cmp++;
    if (result[(DIM-1)*ACC_W +: ACC_W] !== ACC_W'(3 * (DIM - 1))) begin
      n_bad++;
      $display("FAIL interleaved_lane_last: got %0d, want %0d",
               result[(DIM-1)*ACC_W +: ACC_W], 3 * (DIM - 1));
    end
    do_clear();
  endtask

  task automatic test_drops();
    do_reset();
    do_write(9, 8'h11);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL drop_bad_sel: got err=%b, want 1", err); end
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL drop_rst_err: got err=%b, want 0", err); end
    randomize_data();
    exp_q.push_back(model_result());
    load_rows(0, 0);
    do_write(0, 8'hAA);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL drop_full: got err=%b, want 1", err); end
    do_write(9, 8'h5A);
    load_rows(1, DIM - 1);
    load_b();
    wait_done("drops");
  endtask

  task automatic test_abort();
    int guard;
    int done_seen;
    do_reset();
    randomize_data();
    load_rows(0, DIM - 1);
    load_b();
    guard = 0;
    while (!busy && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_start: got %b, want 1", busy); end
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b, want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b, want 0", done); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL abort_result: got %h, want 0", result); end
    done_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d done cycles, want 0", done_seen);
    end
    randomize_data();
    exp_q.push_back(model_result());
    load_rows(0, DIM - 1);
    load_b();
    wait_done("abort_reload");
  endtask

  task automatic test_clear_rerun();
    do_write(12, 8'h00);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rerun_err_set: got %b, want 1", err); end
    do_clear();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL clear_done: got %b, want 0", done); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL clear_result: got %h, want 0", result); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL clear_err_kept: got %b, want 1", err); end
    randomize_data();
    exp_q.push_back(model_result());
    load_rows(0, DIM - 1);
    load_b();
    wait_done("rerun");
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rerun_err: got %b, want 1", err); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_ff();
    test_interleaved();
    test_drops();
    test_abort();
    test_clear_rerun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
